multi_cycle_proc: RTL and testbench
===================================

MULTI_CYCLE_PROC -- requirements
Module: multi_cycle_proc

Interface
REQ-001 Parameter XLEN, default 64, datapath, register and PC width (legal values 32 or 64).
REQ-002 Parameter NREGS, default 32, number of architectural registers; X(NREGS-1) is XZR.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
REQ-005 startPC  input  XLEN  PC loaded while Reset is low.
REQ-006 currentPC  output  XLEN  address of the instruction in flight.
REQ-007 imem_req / imem_addr / imem_ack / imem_rdata  out 1 / out XLEN / in 1 / in 32  instruction fetch port.
REQ-008 dmem_req / dmem_we / dmem_addr / dmem_wdata / dmem_ack / dmem_rdata  out 1 / out 1 / out XLEN / out XLEN / in 1 / in XLEN  data port.
REQ-009 halted  output  1  high in HALT state.

Function
REQ-010 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-011 FETCH: imem_req=1, imem_addr=currentPC; on imem_ack capture imem_rdata into IR and go to DECODE in the same edge; ack in the first req cycle SHALL be accepted (1-cycle fetch).
REQ-012 Requests SHALL hold req, addr, we, wdata stable from assertion until the cycle ack is sampled high; req SHALL drop the cycle after ack.
REQ-013 DECODE: read Rn and (Rm, or Rt for STUR/CBZ) into A/B latches; sign-extend immediate into IMM; unknown opcode -> HALT.
REQ-014 Supported: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100 (8-bit).
REQ-015 EXEC: R-type ALU A op B -> WB; LDUR/STUR address A + sext(imm9, IR[20:12]) -> MEM; CBZ evaluates B==0.
REQ-016 CBZ: taken -> PC = PC + (sext(IR[23:5]) << 2); not taken -> PC + 4; next state FETCH (3 cycles minimum).
REQ-017 MEM: dmem_req=1, dmem_we=1 for STUR (wdata=B) else 0; on ack STUR -> PC+4, FETCH; LDUR -> capture dmem_rdata, WB.
REQ-018 WB: write result to Rd/Rt unless Rd = NREGS-1; PC <= PC+4; -> FETCH. Latency: R-type 4, STUR 4, LDUR 5 cycles with zero-wait memories.
REQ-019 Reads of register NREGS-1 SHALL return 0; writes to it SHALL be discarded.
REQ-020 Arithmetic SHALL be XLEN-bit modulo; PC increment wraps at 2^XLEN.
REQ-021 HALT SHALL be terminal until Reset; no requests issued in HALT.

Reset
REQ-022 While Reset low at an edge: state=FETCH, currentPC=startPC, IR=0, all req=0, dmem_we=0, halted=0.
REQ-023 Reset mid-transaction SHALL drop req next cycle; a late ack SHALL be ignored.
REQ-024 Register file contents SHALL NOT be reset.

Configuration
REQ-025 Macro MULTI_CYCLE_PROC_EXT_BRANCH_EN defined: adds CBNZ (10110101, taken when B!=0) and B (000101, PC + (sext(IR[25:0])<<2), DECODE->FETCH, 2-cycle minimum).
REQ-026 Macro undefined: CBNZ and B opcodes SHALL decode as unknown -> HALT.

Structure
REQ-027 Package mcp_pkg SHALL hold state enum, opcode constants, ALU-op enum.
REQ-028 Sub-module mcp_regfile (NREGS x XLEN, 2 read 1 write, XZR rule) SHALL be instantiated once.

Verification
REQ-029 startPC=0x100, ADD X3,X1,X2 with X1=5,X2=7, zero-wait -> X3=12 after 4 cycles, currentPC=0x104.
REQ-030 STUR X3,[X1,#8] X1=0x200 -> dmem_we=1, addr=0x208, wdata=12; imem_ack delayed 3 cycles -> imem_addr/req stable throughout.
REQ-031 LDUR X4,[X1,#-8] -> addr=0x1F8, X4=dmem_rdata after 5 cycles; ADD X31,X1,X2 -> X31 still reads 0.
REQ-032 CBZ X5,#-2 with X5=0 at PC=0x110 -> PC=0x108; X5=1 -> PC=0x114; illegal opcode 0xFFFFFFFF -> halted=1, no further req.
REQ-033 Reset low while dmem_req pending -> req low next cycle, currentPC=startPC; with EXT_BRANCH_EN, B #4 at 0x100 -> PC=0x110 after 2 cycles.

Source files
------------

// File: rtl/mcp_pkg.sv
// mcp_pkg: FSM state, instruction-class, ALU-op enums and opcode constants
// shared by the multi-cycle LEGv8-subset processor.
package mcp_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_op_t;

    // Instruction class resolved from IR; K_BAD covers every unsupported encoding.
    typedef enum logic [2:0] {K_RTYPE, K_LDUR, K_STUR, K_CBZ, K_CBNZ, K_B, K_BAD} kind_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

endpackage

// File: rtl/mcp_regfile.sv
// mcp_regfile: NREGS x XLEN register file, two registered read ports, one
// write port. The top register (XZR) reads as zero and ignores writes.
// Contents are deliberately not reset.
module mcp_regfile
    import mcp_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            Clk,
    input  logic            re,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);
    localparam logic [AW-1:0] ZR = AW'(NREGS - 1);

    logic [XLEN-1:0] mem [NREGS];

    // Write port; writes aimed at XZR are dropped.
    always_ff @(posedge Clk) begin
        if (we && (waddr != ZR)) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read ports act as the A/B operand latches, loaded only on re.
    always_ff @(posedge Clk) begin
        if (re) begin
            rdata_a <= (raddr_a == ZR) ? '0 : mem[raddr_a];
            rdata_b <= (raddr_b == ZR) ? '0 : mem[raddr_b];
        end
    end

endmodule

// File: rtl/multi_cycle_proc.sv
// multi_cycle_proc: FETCH/DECODE/EXEC/MEM/WB/HALT multi-cycle processor for
// ADD, SUB, AND, ORR, LDUR, STUR and CBZ with req/ack instruction and data ports.
// Optional macro MULTI_CYCLE_PROC_EXT_BRANCH_EN adds CBNZ and B; without it
// those encodings halt like any other unknown opcode.
module multi_cycle_proc
    import mcp_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [XLEN-1:0] startPC,
    output logic [XLEN-1:0] currentPC,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            halted
);
    localparam int AW = $clog2(NREGS);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state_reg, state_next;
    logic            active_reg;
    logic [XLEN-1:0] pc_reg, imm_reg, res_reg, imm_dec, alu_y, op_a, op_b;
    logic [31:0]     ir_reg;
    kind_t           kind;
    alu_op_t         alu_op;
    logic            rf_re, rf_we, branch_taken;
    logic [AW-1:0]   ra_a, ra_b, rf_waddr;

    // Instruction classification from IR.
    always_comb begin
        kind   = K_BAD;
        alu_op = ALU_ADD;
        if      (ir_reg[31:21] == OP_ADD)  kind = K_RTYPE;
        else if (ir_reg[31:21] == OP_SUB)  begin kind = K_RTYPE; alu_op = ALU_SUB; end
        else if (ir_reg[31:21] == OP_AND)  begin kind = K_RTYPE; alu_op = ALU_AND; end
        else if (ir_reg[31:21] == OP_ORR)  begin kind = K_RTYPE; alu_op = ALU_ORR; end
        else if (ir_reg[31:21] == OP_LDUR) kind = K_LDUR;
        else if (ir_reg[31:21] == OP_STUR) kind = K_STUR;
        else if (ir_reg[31:24] == OP_CBZ)  kind = K_CBZ;
`ifdef MULTI_CYCLE_PROC_EXT_BRANCH_EN
        else if (ir_reg[31:24] == OP_CBNZ) kind = K_CBNZ;
        else if (ir_reg[31:26] == OP_B)    kind = K_B;
`endif
    end

    // Sign-extended immediate; branch offsets are pre-scaled to bytes.
    always_comb begin
        imm_dec = {{(XLEN-9){ir_reg[20]}}, ir_reg[20:12]};
        if (kind == K_CBZ || kind == K_CBNZ) begin
            imm_dec = {{(XLEN-21){ir_reg[23]}}, ir_reg[23:5], 2'b00};
        end
`ifdef MULTI_CYCLE_PROC_EXT_BRANCH_EN
        if (kind == K_B) begin
            imm_dec = {{(XLEN-28){ir_reg[25]}}, ir_reg[25:0], 2'b00};
        end
`endif
    end

    // ALU for R-type operations plus the conditional-branch test on B.
    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = op_a - op_b;
            ALU_AND: alu_y = op_a & op_b;
            ALU_ORR: alu_y = op_a | op_b;
            default: alu_y = op_a + op_b;
        endcase
        branch_taken = (kind == K_CBNZ) ? (op_b != '0) : (op_b == '0);
    end

    assign ra_a     = AW'(ir_reg[9:5]);
    assign ra_b     = (kind == K_STUR || kind == K_CBZ || kind == K_CBNZ) ? AW'(ir_reg[4:0])
                                                                          : AW'(ir_reg[20:16]);
    assign rf_waddr = AW'(ir_reg[4:0]);

    mcp_regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_regfile (
        .Clk     (Clk),
        .re      (rf_re),
        .raddr_a (ra_a),
        .raddr_b (ra_b),
        .rdata_a (op_a),
        .rdata_b (op_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (res_reg)
    );

    // Next-state and handshake outputs. active_reg keeps imem_req low in the
    // cycle straight after reset so a stale ack cannot be taken.
    always_comb begin
        state_next = state_reg;
        imem_req   = (state_reg == FETCH) && active_reg;
        dmem_req   = (state_reg == MEM);
        dmem_we    = (state_reg == MEM) && (kind == K_STUR);
        rf_re      = 1'b0;
        rf_we      = 1'b0;
        case (state_reg)
            FETCH:  if (imem_req && imem_ack) state_next = DECODE;
            DECODE: begin
                rf_re = 1'b1;
                if (kind == K_BAD)    state_next = HALT;
                else if (kind == K_B) state_next = FETCH;
                else                  state_next = EXEC;
            end
            EXEC: begin
                if (kind == K_RTYPE)                         state_next = WB;
                else if (kind == K_LDUR || kind == K_STUR)   state_next = MEM;
                else                                         state_next = FETCH;
            end
            MEM:  if (dmem_ack) state_next = (kind == K_STUR) ? FETCH : WB;
            WB: begin
                rf_we      = 1'b1;
                state_next = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    // Control state: FSM, PC, IR; all cleared by the synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg  <= FETCH;
            pc_reg     <= startPC;
            ir_reg     <= '0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            active_reg <= 1'b1;
            case (state_reg)
                FETCH:  if (imem_req && imem_ack) ir_reg <= imem_rdata;
                DECODE: if (kind == K_B) pc_reg <= pc_reg + imm_dec;
                EXEC: begin
                    if (kind == K_CBZ || kind == K_CBNZ) begin
                        pc_reg <= branch_taken ? pc_reg + imm_reg : pc_reg + PC_STEP;
                    end
                end
                MEM:     if (dmem_ack && kind == K_STUR) pc_reg <= pc_reg + PC_STEP;
                WB:      pc_reg <= pc_reg + PC_STEP;
                default: ;
            endcase
        end
    end

    // Datapath latches: immediate, ALU/address result, load data.
    always_ff @(posedge Clk) begin
        if (state_reg == DECODE) imm_reg <= imm_dec;
        if (state_reg == EXEC)   res_reg <= (kind == K_RTYPE) ? alu_y : op_a + imm_reg;
        if (state_reg == MEM && dmem_ack && kind == K_LDUR) res_reg <= dmem_rdata;
    end

    assign currentPC  = pc_reg;
    assign imem_addr  = pc_reg;
    assign dmem_addr  = res_reg;
    assign dmem_wdata = op_b;
    assign halted     = (state_reg == HALT);

endmodule

// File: tb/tb_multi_cycle_proc.sv
// tb_multi_cycle_proc: random instruction stream with random memory wait
// states, checked against an architectural (ISA-level) model of the processor.
`timescale 1ns/1ps
module tb_multi_cycle_proc;

`ifdef MULTI_CYCLE_PROC_EXT_BRANCH_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif
    localparam logic [10:0] T_ADD = 11'b10001011000, T_SUB = 11'b11001011000;
    localparam logic [10:0] T_AND = 11'b10001010000, T_ORR = 11'b10101010000;
    localparam logic [10:0] T_LDUR = 11'b11111000010, T_STUR = 11'b11111000000;
    localparam logic [7:0]  T_CBZ = 8'b10110100, T_CBNZ = 8'b10110101;
    localparam logic [5:0]  T_B = 6'b000101;
    localparam logic [10:0] ROPS [4] = '{11'b10001011000, 11'b11001011000,
                                         11'b10001010000, 11'b10101010000};

    logic        Clk = 1'b0, Reset = 1'b0;
    logic [63:0] startPC = '0, currentPC, imem_addr, dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic        imem_req, imem_ack = 1'b0, dmem_req, dmem_we, dmem_ack = 1'b0, halted;
    logic [31:0] imem_rdata = '0;

    multi_cycle_proc #(.XLEN(64), .NREGS(32)) dut (
        .Clk(Clk), .Reset(Reset), .startPC(startPC), .currentPC(currentPC),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .halted(halted)
    );

    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int          n_checks = 0, n_fail = 0;
    logic [63:0] mreg [32];
    logic [63:0] mpc = '0;
    bit          have_prev = 1'b0;
    int unsigned prev_ack_cyc = 0;
    int          exp_lat = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (pc 0x%0h)", tag, got, exp, mpc);
        end
    endtask

    function automatic logic [63:0] rreg(input int i);
        return (i == 31) ? 64'd0 : mreg[i];
    endfunction

    function automatic logic [31:0] rtype(input logic [10:0] op, input int rd, input int rn, input int rm);
        logic [4:0] d, n, m;
        d = rd[4:0]; n = rn[4:0]; m = rm[4:0];
        return {op, m, 6'b0, n, d};
    endfunction

    function automatic logic [31:0] dtype(input logic [10:0] op, input int rt, input int rn, input int imm);
        logic [4:0] t, n;
        logic [8:0] i9;
        t = rt[4:0]; n = rn[4:0]; i9 = imm[8:0];
        return {op, i9, 2'b00, n, t};
    endfunction

    function automatic logic [31:0] cbtype(input logic [7:0] op, input int rt, input int imm);
        logic [4:0]  t;
        logic [18:0] i19;
        t = rt[4:0]; i19 = imm[18:0];
        return {op, i19, t};
    endfunction

    function automatic int rnd_wait();
        return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
    endfunction

    function automatic logic [31:0] gen_instr();
        int k, rd, rn, rm, imm;
        logic [25:0] i26;
        k  = int'($urandom_range(0, 99));
        rd = int'($urandom_range(0, 31)); rn = int'($urandom_range(0, 31));
        rm = int'($urandom_range(0, 31));
        imm = int'($urandom_range(0, 63)) - 32;
        if (k < 40) begin
            if ($urandom_range(0, 9) == 0) rd = 31;
            if ($urandom_range(0, 5) == 0) rm = rn;
            return rtype(ROPS[$urandom_range(0, 3)], rd, rn, rm);
        end
        if (k < 60) return dtype(T_LDUR, rd, rn, imm);
        if (k < 80) return dtype(T_STUR, rd, rn, imm);
        imm = int'($urandom_range(0, 16)) - 8;
        if ($urandom_range(0, 1) == 0) rd = 31;
        if (k < 94) return cbtype(T_CBZ, rd, imm);
        if (k < 97) return cbtype(T_CBNZ, rd, imm);
        i26 = imm[25:0];
        if (k < 99) return {T_B, i26};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic wait_req(input bit is_imem, output bit ok);
        int n = 0;
        while (((is_imem ? imem_req : dmem_req) !== 1'b1) && n < 40) begin
            if (is_imem) check_eq("stray_dmem_req", {63'b0, dmem_req}, 64'd0);
            @(negedge Clk);
            n++;
        end
        ok = (n < 40);
        check_eq(is_imem ? "imem_req_timeout" : "dmem_req_timeout", {63'b0, ok}, 64'd1);
    endtask

    task automatic do_reset(input logic [63:0] spc);
        Reset = 1'b0; startPC = spc; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(negedge Clk);
        check_eq("rst_currentPC", currentPC, spc);
        check_eq("rst_imem_req", {63'b0, imem_req}, 64'd0);
        check_eq("rst_dmem_req", {63'b0, dmem_req}, 64'd0);
        check_eq("rst_dmem_we", {63'b0, dmem_we}, 64'd0);
        check_eq("rst_halted", {63'b0, halted}, 64'd0);
        Reset = 1'b1;
        startPC = {$urandom, $urandom};
        mpc = spc; have_prev = 1'b0;
    endtask

    // Execute one instruction against the DUT and the architectural model.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                             input logic [63:0] ld_data, input bit rst_mid, output bit hlt);
        bit ok, is_ld, is_st, taken;
        logic [10:0] op11;
        int rd, rn, rm;
        logic [63:0] a, b, addr, res;
        hlt = 1'b0;
        wait_req(1'b1, ok);
        if (!ok) begin hlt = 1'b1; return; end
        if (have_prev) check_eq("latency", 64'(cyc - prev_ack_cyc), 64'(exp_lat));
        check_eq("currentPC", currentPC, mpc);
        check_eq("halted_run", {63'b0, halted}, 64'd0);
        for (int k = 0; k < iw; k++) begin
            check_eq("imem_addr_hold", imem_addr, mpc);
            check_eq("imem_req_hold", {63'b0, imem_req}, 64'd1);
            @(negedge Clk);
        end
        check_eq("imem_addr", imem_addr, mpc);
        imem_ack = 1'b1; imem_rdata = ins; prev_ack_cyc = cyc;
        @(negedge Clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        check_eq("imem_req_drop", {63'b0, imem_req}, 64'd0);

        op11 = ins[31:21];
        rd = int'(ins[4:0]); rn = int'(ins[9:5]); rm = int'(ins[20:16]);
        a = rreg(rn);
        is_ld = (op11 == T_LDUR); is_st = (op11 == T_STUR);
        if (op11 == T_ADD || op11 == T_SUB || op11 == T_AND || op11 == T_ORR) begin
            b = rreg(rm);
            if (op11 == T_ADD)      res = a + b;
            else if (op11 == T_SUB) res = a - b;
            else if (op11 == T_AND) res = a & b;
            else                    res = a | b;
            if (rd != 31) mreg[rd] = res;
            mpc = mpc + 64'd4; exp_lat = 4; have_prev = 1'b1;
        end else if (is_ld || is_st) begin
            addr = a + 64'($signed(ins[20:12]));
            b = rreg(rd);
            wait_req(1'b0, ok);
            if (!ok) begin hlt = 1'b1; return; end
            for (int k = 0; k < dw; k++) begin
                check_eq("dmem_we_hold", {63'b0, dmem_we}, {63'b0, is_st});
                check_eq("dmem_addr_hold", dmem_addr, addr);
                if (is_st) check_eq("dmem_wdata_hold", dmem_wdata, b);
                if (rst_mid && k == 1) begin
                    Reset = 1'b0; startPC = 64'h180;
                    @(negedge Clk);
                    check_eq("midrst_dmem_req", {63'b0, dmem_req}, 64'd0);
                    check_eq("midrst_imem_req", {63'b0, imem_req}, 64'd0);
                    check_eq("midrst_currentPC", currentPC, 64'h180);
                    Reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = ld_data;
                    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
                    @(negedge Clk);
                    dmem_ack = 1'b0; imem_ack = 1'b0;
                    check_eq("midrst_late_ack_req", {63'b0, imem_req}, 64'd1);
                    check_eq("midrst_pc_after", currentPC, 64'h180);
                    mpc = 64'h180; have_prev = 1'b0;
                    return;
                end
                @(negedge Clk);
            end
            check_eq("dmem_req", {63'b0, dmem_req}, 64'd1);
            check_eq("dmem_we", {63'b0, dmem_we}, {63'b0, is_st});
            check_eq("dmem_addr", dmem_addr, addr);
            if (is_st) check_eq("dmem_wdata", dmem_wdata, b);
            dmem_ack = 1'b1; dmem_rdata = ld_data;
            @(negedge Clk);
            dmem_ack = 1'b0; dmem_rdata = {$urandom, $urandom};
            check_eq("dmem_req_drop", {63'b0, dmem_req}, 64'd0);
            if (is_ld && rd != 31) mreg[rd] = ld_data;
            mpc = mpc + 64'd4; exp_lat = (is_ld ? 5 : 4) + dw; have_prev = 1'b1;
        end else if (ins[31:24] == T_CBZ || (EXT && ins[31:24] == T_CBNZ)) begin
            b = rreg(rd);
            taken = (ins[31:24] == T_CBZ) ? (b == 64'd0) : (b != 64'd0);
            mpc = taken ? mpc + (64'($signed(ins[23:5])) << 2) : mpc + 64'd4;
            exp_lat = 3; have_prev = 1'b1;
        end else if (EXT && ins[31:26] == T_B) begin
            mpc = mpc + (64'($signed(ins[25:0])) << 2);
            exp_lat = 2; have_prev = 1'b1;
        end else begin
            @(negedge Clk);
            check_eq("halted", {63'b0, halted}, 64'd1);
            for (int k = 0; k < 6; k++) begin
                imem_ack = 1'b1; dmem_ack = 1'b1;
                @(negedge Clk);
                check_eq("halt_no_imem_req", {63'b0, imem_req}, 64'd0);
                check_eq("halt_no_dmem_req", {63'b0, dmem_req}, 64'd0);
                check_eq("halt_stays", {63'b0, halted}, 64'd1);
            end
            imem_ack = 1'b0; dmem_ack = 1'b0;
            hlt = 1'b1;
        end
    endtask

    initial begin
        bit hlt;
        logic [63:0] v;
        do_reset(64'h100);
        // Registers are not reset, so load every one through LDUR [XZR,#8*i].
        for (int i = 0; i < 31; i++) begin
            v = (i == 1) ? 64'd5 : (i == 2) ? 64'd7 : {$urandom, $urandom};
            run_instr(dtype(T_LDUR, i, 31, i * 8), rnd_wait(), rnd_wait(), v, 1'b0, hlt);
        end
        run_instr(rtype(T_ADD, 3, 1, 2), 0, 0, '0, 1'b0, hlt);
        run_instr(dtype(T_STUR, 3, 31, 8), 3, 0, '0, 1'b0, hlt);
        run_instr(dtype(T_LDUR, 4, 1, -8), 0, 0, 64'h1234_5678_9ABC_DEF0, 1'b0, hlt);
        run_instr(dtype(T_STUR, 4, 31, 0), 0, 2, '0, 1'b0, hlt);
        run_instr(rtype(T_ADD, 31, 1, 2), 0, 0, '0, 1'b0, hlt);
        run_instr(dtype(T_STUR, 31, 31, 0), 0, 0, '0, 1'b0, hlt);
        run_instr(cbtype(T_CBZ, 31, -2), 0, 0, '0, 1'b0, hlt);
        run_instr(cbtype(T_CBZ, 3, -2), 0, 0, '0, 1'b0, hlt);
        do_reset(64'h100);
        run_instr({T_B, 26'd4}, 0, 0, '0, 1'b0, hlt);
        if (hlt) do_reset(64'h100);
        for (int n = 0; n < 250; n++) begin
            run_instr(gen_instr(), rnd_wait(), rnd_wait(), {$urandom, $urandom}, 1'b0, hlt);
            if (hlt) do_reset({32'b0, $urandom_range(0, 255), 2'b00});
        end
        do_reset(64'h100);
        run_instr(dtype(T_LDUR, 4, 31, 0), 0, 4, 64'hDEAD_BEEF, 1'b1, hlt);
        run_instr(dtype(T_STUR, 4, 31, 16), 0, 0, '0, 1'b0, hlt);
        run_instr(32'hFFFF_FFFF, 1, 0, '0, 1'b0, hlt);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
